// File: rtl/i2s_mic_rx_master.sv
// I2S receive master for daisy-chained microphones: bclk/ws generation, slot assembly, FWFT output FIFO.
// Optional dropped-word counter on ovf_cnt_o is built only when I2S_RX_OVF_CNT_EN is defined.
`timescale 1ns/1ps

module i2s_mic_rx_master #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_SLOTS  = 2,
    parameter int FRAME_BCLK = 80,
    parameter int FIFO_DEPTH = 4,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              lsb_first_i,
    output logic              bclk_o,
    output logic              ws_o,
    input  logic              dout_i,
    output logic [31:0]       data_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overflow_o,
    input  logic              clear_ovf_i,
    output logic [15:0]       ovf_cnt_o
);

    // state | meaning
    // IDLE  | bclk parked low, divider held, waiting for en_i
    // WS    | ws_o high, waiting for the first bclk fall (F1)
    // SHIFT | sampling dout_i on every fall, pushing a word every 32 bits
    // GAP   | all slots received, counting falls to the end of the frame
    typedef enum logic [1:0] {S_IDLE, S_WS, S_SHIFT, S_GAP} state_t;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FCNT_W = $clog2(FRAME_BCLK + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [FCNT_W-1:0]   fall_cnt;
    logic [4:0]          bit_cnt;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [31:0]         shreg, shreg_nxt;
    logic                lsb_q;

    logic running, div_tc, fall, frame_end, last_slot;
    logic start, sample, ws_clr, word_done;

    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [SLOT_W-1:0] fifo_slot [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              full, pop, push_ok, drop;

    assign running   = (state != S_IDLE);
    assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall      = running && div_tc && bclk_o;
    assign frame_end = fall && (fall_cnt == FCNT_W'(FRAME_BCLK - 1));
    assign last_slot = (slot_cnt == SLOT_W'(NUM_SLOTS - 1));
    assign word_done = sample && (bit_cnt == 5'd31);
    assign shreg_nxt = lsb_q ? {dout_i, shreg[31:1]} : {shreg[30:0], dout_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en_i) state_nxt = S_WS;
            S_WS:    if (fall) state_nxt = S_SHIFT;
            S_SHIFT: if (word_done && last_slot) state_nxt = S_GAP;
            S_GAP:   if (frame_end) state_nxt = en_i ? S_WS : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        sample = 1'b0;
        ws_clr = 1'b0;
        case (state)
            S_IDLE:  start = en_i;
            S_WS: begin
                sample = fall;
                ws_clr = fall;
            end
            S_SHIFT: sample = fall;
            S_GAP:   start = frame_end && en_i;
            default: ;
        endcase
    end

    // The divider restarts from 0 on F0 in both entry paths, so every frame has identical timing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            bclk_o  <= 1'b0;
        end else if (!running) begin
            div_cnt <= '0;
            bclk_o  <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk_o  <= ~bclk_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ws_o     <= 1'b0;
            lsb_q    <= 1'b0;
            fall_cnt <= '0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            shreg    <= '0;
        end else begin
            if (start)       ws_o <= 1'b1;
            else if (ws_clr) ws_o <= 1'b0;

            if (start) begin
                lsb_q    <= lsb_first_i;
                fall_cnt <= '0;
                bit_cnt  <= '0;
                slot_cnt <= '0;
            end else begin
                if (fall) fall_cnt <= fall_cnt + 1'b1;
                if (sample) begin
                    shreg   <= shreg_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (word_done) slot_cnt <= last_slot ? '0 : slot_cnt + 1'b1;
                end
            end
        end
    end

    // A pop in the same clk frees a slot, so a push into a full FIFO is still accepted then.
    assign pop     = valid_o && ready_i;
    assign full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;
    assign valid_o = (fifo_cnt != '0);
    assign data_o  = fifo_data[rd_ptr];
    assign slot_o  = fifo_slot[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= shreg_nxt;
            fifo_slot[wr_ptr] <= slot_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)     rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_ovf_i) overflow_o <= 1'b0;
        else if (drop)            overflow_o <= 1'b1;
    end

`ifdef I2S_RX_OVF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_ovf_i)          ovf_cnt_o <= '0;
        else if (drop && ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
`else
    assign ovf_cnt_o = '0;
`endif

endmodule
